control_fsm: RTL and testbench
==============================

# control_fsm

Multicycle main control unit for the ARMv4 datapath. It decodes the instruction fields latched in the instruction register and walks a 10-state Moore FSM. Each cycle it emits the datapath mux selects and the unconditioned write requests (PCS, RegW, MemW, FlagW). Those requests are the inputs the condition-check logic qualifies with the condition code before they reach the register file, data memory, PC and flag registers.

## Interface
Parameters: none.

Ports:
- `clk`: input, 1 bit. Single clock. All state changes on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `Op`: input, 2 bits. Instr[27:26]; 00 = DP, 01 = MEM, 10 = branch.
- `Funct`: input, 6 bits. Instr[25:20]; [5] = I, [4:1] = cmd, [0] = S or L.
- `Rd`: input, 4 bits. Instr[15:12].
- `PCS`: output, 1 bit. PC write request, before condition qualification.
- `RegW`: output, 1 bit. Register file write request.
- `MemW`: output, 1 bit. Data memory write request.
- `FlagW`: output, 2 bits. [1] requests an N,Z update; [0] requests a C,V update.
- `IRWrite`: output, 1 bit. Instruction register load enable.
- `NextPC`: output, 1 bit. Unconditional PC+4 write.
- `AdrSrc`: output, 1 bit. Memory address select; 0 = PC, 1 = ALU result.
- `ResultSrc`: output, 2 bits. 00 = ALUOut, 01 = read data, 10 = ALU result.
- `ALUSrcA`: output, 1 bit. 0 = register A, 1 = PC.
- `ALUSrcB`: output, 2 bits. 00 = register B, 01 = extended immediate, 10 = constant 4.
- `ALUControl`: output, 2 bits. 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- `ImmSrc`: output, 2 bits. Equals `Op`.
- `RegSrc`: output, 2 bits. [0] = (Op==10), [1] = (Op==01).

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.

Transitions:
- FETCH→DECODE.
- DECODE branches on `Op`:
  - Op=01 → MEMADR.
  - Op=00 with Funct[5]=0 → EXECR.
  - Op=00 with Funct[5]=1 → EXECI.
  - Op=10 → BRANCH.
  - Op=11 → FETCH. This is an undefined opcode; no writes occur.
- MEMADR→MEMRD if Funct[0]=1, otherwise MEMWR.
- MEMRD→MEMWB→FETCH.
- MEMWR→FETCH.
- EXECR and EXECI→ALUWB.
- ALUWB→FETCH.
- BRANCH→FETCH.

Per-state outputs. Any output not listed for a state is 0.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. This precomputes PC+8.
- MEMADR: ALUSrcA=0, ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.

Derived signals:
- PCS = Branch | (RegW & Rd==4'hF).
- ALU decode when ALUOp=1:
  - cmd 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (cmd is ADD or SUB).
  - An unsupported cmd gives ALUControl=00 and FlagW=00.
- ALU decode when ALUOp=0: ALUControl=00, FlagW=00.

## Timing
- The state register is the only storage. It resets asynchronously to FETCH.
- All outputs are combinational from the state and the current `Op`/`Funct`/`Rd`. There is no output register.
- While `rst`=0, IRWrite, NextPC, PCS, RegW, MemW and FlagW are forced to 0. The mux selects show their FETCH values.
- On `rst` release, the first rising edge executes FETCH.
- Instruction latency: LDR 5 cycles; STR 4; DP 4; B 3; undefined opcode 2.
- The fields are sampled in DECODE and later states. The IR is loaded at the end of FETCH, so the fields are stable from DECODE until the next FETCH.
- Reset asserted mid-instruction: the write strobes drop immediately. The state becomes FETCH with no partial writeback.

## Configuration
- `CTRL_CMP_NOWRITE_EN` defined:
  - A DP cmd of 1010 with S=1 (CMP) decodes as SUB with FlagW=11.
  - EXECR and EXECI go directly to FETCH, skipping ALUWB, so RegW is never asserted. A CMP takes 3 cycles.
- `CTRL_CMP_NOWRITE_EN` not defined:
  - cmd 1010 is an unsupported cmd: ALUControl=00, FlagW=00.
  - The normal 4-cycle path with ALUWB still runs.

## Structure
- Package `control_pkg` holds:
  - the `state_t` enum (4-bit encoding);
  - localparams for the Op encodings, the ALUControl codes, and the DP cmd codes (ADD, SUB, AND, ORR, CMP).
- Sub-module `alu_decoder` covers the purely combinational ALU decode:
  - inputs: ALUOp, Funct[4:0];
  - outputs: ALUControl, FlagW.
- `control_fsm` contains the state register, next-state logic, output decode, PCS logic, ImmSrc and RegSrc.

## Test plan
- Reset hold and release:
  - With `rst`=0, every write strobe is 0 and ALUSrcB=10.
  - After release, cycle 0 shows IRWrite=NextPC=1.
- ADDS R1,R2,R3 (Op=00, Funct=001001, Rd=1):
  - Sequence FETCH, DECODE, EXECR, ALUWB.
  - EXECR shows ALUControl=00 and FlagW=11.
  - ALUWB shows RegW=1 and PCS=0.
- LDR R15 (Op=01, Funct=011001, Rd=15):
  - 5-cycle sequence; MEMRD shows AdrSrc=1.
  - MEMWB shows ResultSrc=01, RegW=1 and PCS=1.
- STR (Op=01, Funct[0]=0) then B (Op=10):
  - STR shows MemW=1 only in cycle 4.
  - B shows PCS=1, ResultSrc=10 and ALUSrcB=01 in cycle 3, then returns to FETCH.
- ANDS with I=1 (Funct=100001):
  - Passes through EXECI with ALUSrcB=01, ALUControl=10 and FlagW=10.
- `rst` pulled low in MEMWR:
  - MemW falls in the same cycle, without waiting for a clock edge.
  - After release the FSM is in FETCH.
- Op=11 returns to FETCH after DECODE with no writes.
- With `CTRL_CMP_NOWRITE_EN`, CMP (Funct=010101):
  - FlagW=11 and ALUControl=01 in EXECR.
  - No ALUWB state and no RegW.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle ARMv4 main control unit.
// Optional CMP-without-writeback support is enabled by CTRL_CMP_NOWRITE_EN.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Funct[4:0] = {cmd, S}
  function automatic logic is_cmp(input logic [4:0] funct);
    return (funct[4:1] == CMD_CMP) && funct[0];
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation and flag-write decode for DP instructions.
// CTRL_CMP_NOWRITE_EN adds CMP as a flag-only SUB.
module alu_decoder
  import control_pkg::*;
(
  input  logic       ALUOp,
  input  logic [4:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = '0;
    if (ALUOp) begin
      unique case (cmd)
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          FlagW      = {s_bit, s_bit};
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          FlagW      = {s_bit, s_bit};
        end
        CMD_AND: begin
          ALUControl = ALU_AND;
          FlagW      = {s_bit, 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALU_ORR;
          FlagW      = {s_bit, 1'b0};
        end
`ifdef CTRL_CMP_NOWRITE_EN
        CMD_CMP: begin
          if (s_bit) begin
            ALUControl = ALU_SUB;
            FlagW      = 2'b11;
          end
        end
`endif
        default: begin
          ALUControl = ALU_ADD;
          FlagW      = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle ARMv4 main control FSM: state register, next-state, Moore decode.
// Build option CTRL_CMP_NOWRITE_EN: CMP skips ALUWB and writes flags only.
module control_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  state_t state_q, state_d;

  logic       alu_op;
  logic       branch;
  logic       reg_w_raw;
  logic       mem_w_raw;
  logic       ir_write_raw;
  logic       next_pc_raw;
  logic [1:0] flag_w_raw;
  logic       skip_wb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

`ifdef CTRL_CMP_NOWRITE_EN
  assign skip_wb = is_cmp(Funct[4:0]);
`else
  assign skip_wb = 1'b0;
`endif

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = skip_wb ? S_FETCH : S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    branch       = 1'b0;
    alu_op       = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        next_pc_raw  = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        mem_w_raw = 1'b1;
      end
      S_EXECR:  alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB:  reg_w_raw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .Funct      (Funct[4:0]),
    .ALUControl (ALUControl),
    .FlagW      (flag_w_raw)
  );

  // Strobes are gated by rst directly so they drop without waiting for an edge.
  assign IRWrite = ir_write_raw & rst;
  assign NextPC  = next_pc_raw & rst;
  assign RegW    = reg_w_raw & rst;
  assign MemW    = mem_w_raw & rst;
  assign FlagW   = flag_w_raw & {2{rst}};
  assign PCS     = (branch | (reg_w_raw & (Rd == 4'hF))) & rst;

  assign ImmSrc  = Op;
  assign RegSrc  = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: a spec-level model queues per-cycle outputs,
// a negedge monitor pops and compares; directed cases then randomized instructions.
module tb_control_fsm;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic [1:0] flagw;
    logic       irw;
    logic       npc;
    logic       adr;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] imm;
    logic [1:0] regsrc;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] op = '0;
  logic [5:0] funct = '0;
  logic [3:0] rd = '0;

  logic       PCS, RegW, MemW, IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  outs_t      act;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          mon_en = 1'b0;

  outs_t exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  control_fsm dut (
    .clk        (clk),
    .rst        (rst_n),
    .Op         (op),
    .Funct      (funct),
    .Rd         (rd),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .FlagW      (FlagW),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc)
  );

  assign act = '{pcs: PCS, regw: RegW, memw: MemW, flagw: FlagW, irw: IRWrite,
                 npc: NextPC, adr: AdrSrc, res: ResultSrc, srca: ALUSrcA,
                 srcb: ALUSrcB, aluc: ALUControl, imm: ImmSrc, regsrc: RegSrc};

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic bit cmp_mode(input logic [5:0] f);
`ifdef CTRL_CMP_NOWRITE_EN
    return (f[4:1] == 4'd10) && f[0];
`else
    return 1'b0;
`endif
  endfunction

  // Reference outputs for one step of an instruction, from the per-step table.
  function automatic outs_t model(input string ph, input logic [1:0] o_op,
                                  input logic [5:0] f, input logic [3:0] r);
    outs_t o;
    bit    br;
    int    cmd;
    bit    s;
    o = '0;
    br = 1'b0;
    cmd = int'(f[4:1]);
    s = f[0];
    o.imm = o_op;
    o.regsrc = {o_op == 2'd1, o_op == 2'd2};
    case (ph)
      "FETCH":  begin o.irw = 1; o.npc = 1; o.srca = 1; o.srcb = 2; o.res = 2; end
      "DECODE": begin o.srca = 1; o.srcb = 2; o.res = 2; end
      "MEMADR": o.srcb = 1;
      "MEMRD":  o.adr = 1;
      "MEMWB":  begin o.res = 1; o.regw = 1; end
      "MEMWR":  begin o.adr = 1; o.memw = 1; end
      "ALUWB":  o.regw = 1;
      "BRANCH": begin o.srcb = 1; o.res = 2; br = 1'b1; end
      default: ;
    endcase
    if (ph == "EXECR" || ph == "EXECI") begin
      o.srcb = (ph == "EXECI") ? 2'd1 : 2'd0;
      if (cmd == 4)       begin o.aluc = 0; o.flagw = {s, s}; end
      else if (cmd == 2)  begin o.aluc = 1; o.flagw = {s, s}; end
      else if (cmd == 0)  begin o.aluc = 2; o.flagw = {s, 1'b0}; end
      else if (cmd == 12) begin o.aluc = 3; o.flagw = {s, 1'b0}; end
      else if (cmp_mode(f)) begin o.aluc = 1; o.flagw = 2'b11; end
    end
    o.pcs = br || (o.regw && r == 4'd15);
    return o;
  endfunction

  function automatic outs_t reset_exp(input logic [1:0] o_op);
    outs_t o;
    o = model("FETCH", o_op, 6'd0, 4'd0);
    o.irw = 0;
    o.npc = 0;
    return o;
  endfunction

  // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [1:0] i_op, input logic [5:0] f, input logic [3:0] r);
    string ph[$];
    op = i_op;
    funct = f;
    rd = r;
    ph = '{"FETCH", "DECODE"};
    case (i_op)
      2'd0: begin
        ph.push_back(f[5] ? "EXECI" : "EXECR");
        if (!cmp_mode(f)) ph.push_back("ALUWB");
      end
      2'd1: ph = f[0] ? '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB"}
                      : '{"FETCH", "DECODE", "MEMADR", "MEMWR"};
      2'd2: ph.push_back("BRANCH");
      default: ;
    endcase
    foreach (ph[k]) begin
      exp_q.push_back(model(ph[k], i_op, f, r));
      name_q.push_back(ph[k]);
    end
    repeat (ph.size()) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: got %h expected none", act);
      end else begin
        outs_t e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL step_%s: got %h expected %h (op=%b funct=%b rd=%0d) at %0t",
                   nm, act, e, op, funct, rd, $time);
        end
      end
    end
  end

  initial begin
    logic [3:0] cmds[6];
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10, 4'd7};

    op = 2'd1; funct = 6'b011001; rd = 4'd15;
    #3;
    check("reset_outputs", 32'(act), 32'(reset_exp(2'd1)));
    check("reset_alusrcb", 32'(ALUSrcB), 32'd2);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_outputs", 32'(act), 32'(reset_exp(2'd1)));
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_instr(2'd0, 6'b001001, 4'd1);    // ADDS R1,R2,R3
    run_instr(2'd1, 6'b011001, 4'd15);   // LDR R15
    run_instr(2'd1, 6'b011000, 4'd3);    // STR
    run_instr(2'd2, 6'b100000, 4'd0);    // B
    run_instr(2'd0, 6'b100001, 4'd2);    // ANDS imm
    run_instr(2'd3, 6'b111111, 4'd15);   // undefined
    run_instr(2'd0, 6'b010101, 4'd4);    // CMP
    run_instr(2'd0, 6'b010100, 4'd15);   // cmd 1010, S=0
    run_instr(2'd0, 6'b011000, 4'd15);   // ORR to PC

    for (int i = 0; i < 200; i++) begin
      logic [1:0] r_op;
      logic [5:0] r_f;
      logic [3:0] r_rd;
      r_op = 2'($urandom_range(0, 3));
      r_f  = {1'($urandom), cmds[$urandom_range(0, 5)], 1'($urandom)};
      if ($urandom_range(0, 3) == 0) r_f = 6'($urandom);
      r_rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(r_op, r_f, r_rd);
    end

    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted while in MEMWR of a STR.
    op = 2'd1; funct = 6'b011000; rd = 4'd2;
    repeat (3) @(posedge clk);
    #2;
    check("memwr_before_reset", 32'(act), 32'(model("MEMWR", 2'd1, 6'b011000, 4'd2)));
    rst_n = 1'b0;
    #1;
    check("memw_drops_async", 32'(MemW), 32'd0);
    check("async_reset_outputs", 32'(act), 32'(reset_exp(2'd1)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("fetch_after_release", 32'(act), 32'(model("FETCH", 2'd1, 6'b011000, 4'd2)));
    #1;
    mon_en = 1'b1;
    run_instr(2'd0, 6'b001001, 4'd15);  // ADDS to PC right after reset
    run_instr(2'd2, 6'b000000, 4'd0);
    mon_en = 1'b0;
    check("scoreboard_drained_end", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
